// File: rtl/moving_sum_acc.sv
// Running-sum moving-average filter: circular sample buffer plus one add/subtract accumulator.
// Latency: 3 clock edges from the sampling edge to adc_m_axis_tdata/tvalid; throughput is one sample per clock.
// Backpressure: none on the input; an unread result is overwritten by the next one and o_overrun latches.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_adc_data/i_adc_valid  signed sample and strobe (accepted whenever valid is high and i_clr is low)
//   i_clr                   synchronous clear of window, pipeline, tvalid and o_overrun
//   i_avg_mode              1 = window average, 0 = raw window sum
//   i_offset_bin            1 = invert the MSB of the result word
//   adc_m_axis_*            AXI-Stream style result output
//   o_mov_sum_data          copy of adc_m_axis_tdata
//   o_window_full           DEPTH samples accepted since the last reset or clear
//   o_overrun               sticky: an unread result was overwritten
module moving_sum_acc #(
    parameter int DATA_W     = 24,
    parameter int LOG2_DEPTH = 7,
    parameter int OUT_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_adc_valid,
    input  logic              i_clr,
    input  logic              i_avg_mode,
    input  logic              i_offset_bin,
    output logic [OUT_W-1:0]  adc_m_axis_tdata,
    output logic              adc_m_axis_tvalid,
    input  logic              adc_m_axis_tready,
    output logic [OUT_W-1:0]  o_mov_sum_data,
    output logic              o_window_full,
    output logic              o_overrun
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    // Wide enough to hold DEPTH copies of the most negative sample exactly.
    localparam int ACC_W = DATA_W + LOG2_DEPTH;

    generate
        if (OUT_W < ACC_W) begin : g_bad_out_w
            $error("moving_sum_acc: OUT_W must be at least DATA_W+LOG2_DEPTH");
        end
        if (LOG2_DEPTH < 1 || LOG2_DEPTH > 10) begin : g_bad_depth
            $error("moving_sum_acc: LOG2_DEPTH must be in 1..10");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        [DATA_W-1:0]   r_buf [DEPTH];
    logic        [LOG2_DEPTH-1:0] r_wp;
    logic        [LOG2_DEPTH:0] r_fill;
    logic signed [DATA_W-1:0]   r_new;
    logic signed [DATA_W-1:0]   r_old;
    logic                       r_s1_vld;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_s2_vld;
    logic        [OUT_W-1:0]    r_tdata;
    logic                       r_tvalid;
    logic                       r_overrun;

    logic                       w_accept;
    logic signed [ACC_W-1:0]    w_new_ext;
    logic signed [ACC_W-1:0]    w_old_ext;
    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic signed [ACC_W-1:0]    w_avg;
    logic signed [OUT_W-1:0]    w_sum_ext;
    logic signed [OUT_W-1:0]    w_avg_ext;
    logic        [OUT_W-1:0]    w_base;
    logic        [OUT_W-1:0]    w_res;

    // A clear in the same cycle as a valid sample drops the sample.
    assign w_accept = i_adc_valid & ~i_clr;

    // ------------------------------------------------------------------
    // Stage 1: sample capture and circular buffer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[r_wp] <= i_adc_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp     <= '0;
            r_fill   <= '0;
            r_new    <= '0;
            r_old    <= '0;
            r_s1_vld <= 1'b0;
        end else if (i_clr) begin
            r_wp     <= '0;
            r_fill   <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                // The slot about to be overwritten holds the sample leaving the window
                // (zero while the window is still filling).
                r_new <= i_adc_data;
                r_old <= r_buf[r_wp];
                r_wp  <= r_wp + 1'b1;
                // DEPTH is a power of two, so the top bit alone marks saturation.
                if (!r_fill[LOG2_DEPTH]) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    assign o_window_full = r_fill[LOG2_DEPTH];

    // ------------------------------------------------------------------
    // Stage 2: running-sum accumulator
    // ------------------------------------------------------------------
    assign w_new_ext = ACC_W'(r_new);
    assign w_old_ext = ACC_W'(r_old);
    assign w_acc_nxt = r_acc + w_new_ext - w_old_ext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_s2_vld <= 1'b0;
        end else if (i_clr) begin
            r_acc    <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: result formatting and output register
    // ------------------------------------------------------------------
    // Arithmetic shift: the average rounds toward minus infinity.
    assign w_avg     = r_acc >>> LOG2_DEPTH;
    assign w_sum_ext = OUT_W'(r_acc);
    assign w_avg_ext = OUT_W'(w_avg);
    assign w_base    = i_avg_mode ? w_avg_ext : w_sum_ext;
    assign w_res     = {w_base[OUT_W-1] ^ i_offset_bin, w_base[OUT_W-2:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_clr) begin
            // tdata deliberately keeps its last value across a clear.
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_s2_vld) begin
            r_tdata  <= w_res;
            r_tvalid <= 1'b1;
            // Overwriting a word the consumer has not taken this cycle loses it.
            if (r_tvalid && !adc_m_axis_tready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_tvalid && adc_m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign adc_m_axis_tdata  = r_tdata;
    assign adc_m_axis_tvalid = r_tvalid;
    assign o_mov_sum_data    = r_tdata;
    assign o_overrun         = r_overrun;

endmodule
